// File: rtl/div_seq_ctrl_pkg.sv
// rtl/div_seq_ctrl_pkg.sv - shared divider sequencer constants and state encoding
package mips_defs;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/div_seq_ctrl_step.sv
// rtl/div_seq_ctrl_step.sv - one radix-2 restoring divide iteration (combinational)
module div_step
    import mips_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   R_in,
    input  logic [WIDTH-1:0] Q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   R_out,
    output logic [WIDTH-1:0] Q_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           qBit;

    always_comb begin
        shifted = {R_in[WIDTH-1:0], Q_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        // A set top bit means the true partial remainder already exceeds any divisor.
        qBit    = R_in[WIDTH] || (shifted >= {1'b0, divisor});
        R_out   = qBit ? diff : shifted;
        Q_out   = {Q_in[WIDTH-2:0], qBit};
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - sequencer for the shared iterative DIV/DIVU unit in EX
module div_seq_ctrl
    import mips_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    divState_t        state, stateNext;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   remAcc;
    logic [WIDTH-1:0] quoAcc;
    logic [WIDTH-1:0] divisorReg;
    logic             aSign, bSign, signedOpReg;

    logic [WIDTH:0]   stepR;
    logic [WIDTH-1:0] stepQ;
    logic [WIDTH-1:0] absA, absB;
    logic             divZero, negQuo, negRem;
    logic [WIDTH-1:0] fixQuo, fixRem;

    // Magnitude taken in WIDTH+1 bits so the most negative value stays exact.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic isSigned);
        logic [WIDTH:0] ext;
        ext = {isSigned & v[WIDTH-1], v};
        if (ext[WIDTH]) ext = -ext;
        return ext[WIDTH-1:0];
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .R_in    (remAcc),
        .Q_in    (quoAcc),
        .divisor (divisorReg),
        .R_out   (stepR),
        .Q_out   (stepQ)
    );

    always_comb begin
        absA    = magnitude(opa, signed_op);
        absB    = magnitude(opb, signed_op);
        divZero = (divisorReg == '0);
        negQuo  = signedOpReg & (aSign ^ bSign) & ~divZero;
        negRem  = signedOpReg & aSign;
        fixQuo  = divZero ? '1 : (negQuo ? -stepQ : stepQ);
        fixRem  = negRem ? -stepR[WIDTH-1:0] : stepR[WIDTH-1:0];
    end

    always_comb begin
        stateNext = state;
        case (state)
            DIV_IDLE: if (start && !annul) stateNext = DIV_RUN;
            DIV_RUN: begin
                if (annul)              stateNext = DIV_IDLE;
                else if (count == LAST) stateNext = DIV_DONE;
            end
            DIV_DONE: stateNext = DIV_IDLE;
            default:  stateNext = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= DIV_IDLE;
            count       <= '0;
            remAcc      <= '0;
            quoAcc      <= '0;
            divisorReg  <= '0;
            aSign       <= 1'b0;
            bSign       <= 1'b0;
            signedOpReg <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            state <= stateNext;
            case (state)
                DIV_IDLE: begin
                    if (start && !annul) begin
                        count       <= '0;
                        remAcc      <= '0;
                        quoAcc      <= absA;
                        divisorReg  <= absB;
                        aSign       <= opa[WIDTH-1];
                        bSign       <= opb[WIDTH-1];
                        signedOpReg <= signed_op;
                    end
                end
                DIV_RUN: begin
                    if (!annul) begin
                        remAcc <= stepR;
                        quoAcc <= stepQ;
                        count  <= count + 1'b1;
                        // Results land on the final iteration so they are valid throughout DONE.
                        if (count == LAST) begin
                            quotient  <= fixQuo;
                            remainder <= fixRem;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state == DIV_RUN);
    assign result_valid = (state == DIV_DONE);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - self-checking bench for div_seq_ctrl
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        busy, result_valid;
    logic [31:0] quotient, remainder;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    div_seq_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .signed_op    (signed_op),
        .opa          (opa),
        .opb          (opb),
        .annul        (annul),
        .busy         (busy),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                   output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    // Start at the current cycle N; expects busy N+1..N+32 and a single valid at N+33.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input bit hold, input string tag);
        logic [31:0] eq, er;
        int busyOk;
        refDiv(a, b, sgn, eq, er);
        start = 1'b1; opa = a; opb = b; signed_op = sgn; annul = 1'b0;
        busyOk = 0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (hold) begin
                opa = $urandom; opb = $urandom; signed_op = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1 && result_valid === 1'b0) busyOk++;
        end
        chk({tag, " busy_cycles"}, 32'(busyOk), 32'd32);
        tick();
        chk({tag, " valid"}, {30'd0, busy, result_valid}, 32'd1);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        tick();
        start = 1'b0;
        chk({tag, " single_pulse"}, {30'd0, busy, result_valid}, 32'd0);
        chk({tag, " hold_q"}, quotient, eq);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          sel;

        resetn = 1'b0;
        tick();
        tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset valid", {31'd0, result_valid}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        resetn = 1'b1;
        tick();

        runOp(32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
        runOp(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_m7_2");
        runOp(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, "div_7_m2");
        runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_min_m1");
        runOp(32'd5, 32'd0, 1'b0, 1'b0, "divu_by0");
        runOp(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, "div_neg_by0");

        // Annul mid-run: outputs keep the previous result.
        runOp(32'd1000, 32'd3, 1'b0, 1'b0, "divu_1000_3");
        start = 1'b1; opa = 32'hFFFF; opb = 32'd5; signed_op = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        annul = 1'b1;
        tick();
        annul = 1'b0;
        chk("annul busy", {31'd0, busy}, 32'd0);
        chk("annul valid", {31'd0, result_valid}, 32'd0);
        chk("annul keep_q", quotient, 32'd333);
        chk("annul keep_r", remainder, 32'd1);
        tick();
        chk("annul no_valid", {30'd0, busy, result_valid}, 32'd0);
        runOp(32'd9, 32'd3, 1'b0, 1'b0, "restart_9_3");

        // start held through RUN and DONE with changing operands.
        runOp(32'd12345, 32'd77, 1'b1, 1'b1, "held_start");

        // Reset in the middle of RUN.
        start = 1'b1; opa = 32'd50; opb = 32'd6; signed_op = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
        end
        resetn = 1'b0;
        tick();
        chk("midrun_reset busy", {31'd0, busy}, 32'd0);
        chk("midrun_reset valid", {31'd0, result_valid}, 32'd0);
        chk("midrun_reset q", quotient, 32'd0);
        chk("midrun_reset r", remainder, 32'd0);
        resetn = 1'b1;
        tick();

        // start and annul together in IDLE: not accepted.
        start = 1'b1; annul = 1'b1; opa = 32'd8; opb = 32'd2;
        tick();
        start = 1'b0; annul = 1'b0;
        chk("start_annul busy", {31'd0, busy}, 32'd0);
        tick();
        chk("start_annul idle", {30'd0, busy, result_valid}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = $urandom;
            rs  = 1'($urandom_range(0, 1));
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            runOp(ra, rb, rs, 1'b0, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
